// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register IDs
// and the decode pipeline-register layout with its bubble (nop) value.
package y86_pkg;

   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   localparam logic [2:0] AOK = 3'd1;
   localparam logic [2:0] HLT = 3'd2;
   localparam logic [2:0] ADR = 3'd3;
   localparam logic [2:0] INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] val_c;
      logic [63:0] val_p;
   } d_reg_t;

   function automatic d_reg_t bubble_d();
      d_reg_t b;
      b.stat  = AOK;
      b.icode = NOP;
      b.ifun  = 4'h0;
      b.ra    = RNONE;
      b.rb    = RNONE;
      b.val_c = '0;
      b.val_p = '0;
      return b;
   endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports, two synchronous
// write ports (M port wins on a shared target), synchronous active-low clear.
module regfile
   import y86_pkg::*;
#(
   parameter int NREGS = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   input  logic [3:0]  dst_e,
   input  logic [63:0] val_e,
   input  logic [3:0]  dst_m,
   input  logic [63:0] val_m
);

   logic [63:0] regs_reg [NREGS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (!rst_n) begin
            regs_reg[i] <= '0;
         end else if (dst_m != RNONE && dst_m == 4'(i)) begin
            regs_reg[i] <= val_m;
         end else if (dst_e != RNONE && dst_e == 4'(i)) begin
            regs_reg[i] <= val_e;
         end
      end
   end

   always_comb begin
      val_a = '0;
      val_b = '0;
      if (src_a != RNONE && int'(src_a) < NREGS) val_a = regs_reg[src_a];
      if (src_b != RNONE && int'(src_b) < NREGS) val_b = regs_reg[src_b];
   end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register-ID decode, operand select.
// Optional macro DECODE_FWD_EN compiles in the E/M/W operand-forwarding network.
module decode_stage
   import y86_pkg::*;
#(
   parameter int NREGS = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  f_stat,
   input  logic [3:0]  f_icode,
   input  logic [3:0]  f_ifun,
   input  logic [3:0]  f_rA,
   input  logic [3:0]  f_rB,
   input  logic [63:0] f_valC,
   input  logic [63:0] f_valP,
   input  logic        D_stall,
   input  logic        D_bubble,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [63:0] M_valE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] m_valM,
   input  logic [3:0]  W_dstE,
   input  logic [63:0] W_valE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valM,
   output logic [2:0]  d_stat,
   output logic [3:0]  d_icode,
   output logic [3:0]  d_ifun,
   output logic [63:0] d_valC,
   output logic [63:0] d_valA,
   output logic [63:0] d_valB,
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   output logic [3:0]  d_dstE,
   output logic [3:0]  d_dstM
);

   d_reg_t      d_reg, d_next;
   logic [63:0] rf_a, rf_b;
   logic [63:0] fwd_a, fwd_b;

   // Stall has priority over bubble.
   always_comb begin
      d_next = d_reg;
      if (!D_stall) begin
         if (D_bubble) begin
            d_next = bubble_d();
         end else begin
            d_next.stat  = f_stat;
            d_next.icode = f_icode;
            d_next.ifun  = f_ifun;
            d_next.ra    = f_rA;
            d_next.rb    = f_rB;
            d_next.val_c = f_valC;
            d_next.val_p = f_valP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) d_reg <= bubble_d();
      else        d_reg <= d_next;
   end

   always_comb begin
      d_srcA = RNONE;
      d_srcB = RNONE;
      d_dstE = RNONE;
      d_dstM = RNONE;
      case (d_reg.icode)
         RRMOVQ, RMMOVQ, OPQ, PUSHQ: d_srcA = d_reg.ra;
         RET, POPQ:                  d_srcA = RSP;
         default:                    d_srcA = RNONE;
      endcase
      case (d_reg.icode)
         RMMOVQ, MRMOVQ, OPQ:        d_srcB = d_reg.rb;
         CALL, RET, PUSHQ, POPQ:     d_srcB = RSP;
         default:                    d_srcB = RNONE;
      endcase
      case (d_reg.icode)
         RRMOVQ, IRMOVQ, OPQ:        d_dstE = d_reg.rb;
         CALL, RET, PUSHQ, POPQ:     d_dstE = RSP;
         default:                    d_dstE = RNONE;
      endcase
      if (d_reg.icode == MRMOVQ || d_reg.icode == POPQ) d_dstM = d_reg.ra;
   end

   regfile #(.NREGS(NREGS)) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .src_a (d_srcA),
      .src_b (d_srcB),
      .val_a (rf_a),
      .val_b (rf_b),
      .dst_e (W_dstE),
      .val_e (W_valE),
      .dst_m (W_dstM),
      .val_m (W_valM)
   );

`ifdef DECODE_FWD_EN
   // Youngest producer wins: checks run oldest-first so later matches override.
   always_comb begin
      fwd_a = rf_a;
      fwd_b = rf_b;
      if (d_srcA == W_dstE) fwd_a = W_valE;
      if (d_srcA == W_dstM) fwd_a = W_valM;
      if (d_srcA == M_dstE) fwd_a = M_valE;
      if (d_srcA == M_dstM) fwd_a = m_valM;
      if (d_srcA == e_dstE) fwd_a = e_valE;
      if (d_srcB == W_dstE) fwd_b = W_valE;
      if (d_srcB == W_dstM) fwd_b = W_valM;
      if (d_srcB == M_dstE) fwd_b = M_valE;
      if (d_srcB == M_dstM) fwd_b = m_valM;
      if (d_srcB == e_dstE) fwd_b = e_valE;
      if (d_srcA == RNONE) fwd_a = '0;
      if (d_srcB == RNONE) fwd_b = '0;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM};
   assign fwd_a = rf_a;
   assign fwd_b = rf_b;
`endif

   assign d_stat  = d_reg.stat;
   assign d_icode = d_reg.icode;
   assign d_ifun  = d_reg.ifun;
   assign d_valC  = d_reg.val_c;
   assign d_valA  = (d_reg.icode == JXX || d_reg.icode == CALL) ? d_reg.val_p : fwd_a;
   assign d_valB  = fwd_b;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: NREGS, default 15, number of architectural 64-bit registers (IDs 0..NREGS-1); ID 4'hF = RNONE.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for the D pipeline register and the register file.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 f_stat  input  3  fetch status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-006 f_icode/f_ifun  input  4/4  fetched instruction and function codes.
REQ-007 f_rA/f_rB  input  4/4  fetched register specifiers; RNONE when absent.
REQ-008 f_valC/f_valP  input  64/64  fetched constant and next PC.
REQ-009 D_stall/D_bubble  input  1/1  pipeline-control hold and nop-inject.
REQ-010 e_dstE/e_valE  input  4/64  execute-stage forwarding source.
REQ-011 M_dstE/M_valE, M_dstM/m_valM  input  4/64 each  memory-stage forwarding sources.
REQ-012 W_dstE/W_valE, W_dstM/W_valM  input  4/64 each  writeback values: register-file write ports and forwarding sources.
REQ-013 d_stat, d_icode/d_ifun  output  3, 4/4  decoded instruction passed to execute.
REQ-014 d_valC, d_valA/d_valB  output  64, 64/64  constant and operands.
REQ-015 d_srcA/d_srcB/d_dstE/d_dstM  output  4 each  register IDs used by hazard control.

Function
REQ-016 The D register SHALL capture all f_* inputs on the rising clk edge when D_stall=0 and D_bubble=0.
REQ-017 When D_stall=1, the D register SHALL hold its contents; stall wins if D_stall and D_bubble are both 1.
REQ-018 When D_bubble=1 and D_stall=0, the D register SHALL load a nop: icode=1, ifun=0, rA=rB=RNONE, valC=valP=0, stat=AOK.
REQ-019 srcA SHALL be rA for icode 2, 4, 6 and A; RSP (4) for 9 and B; RNONE otherwise.
REQ-020 srcB SHALL be rB for icode 4, 5 and 6; RSP for 8, 9, A and B; RNONE otherwise.
REQ-021 dstE SHALL be rB for icode 2, 3 and 6; RSP for 8, 9, A and B; RNONE otherwise; dstM SHALL be rA for icode 5 and B; RNONE otherwise.
REQ-022 All d_* outputs SHALL be combinational from the D register, the register file and the forwarding inputs (zero added latency).
REQ-023 d_valA SHALL be D.valP for icode 7 and 8; otherwise it SHALL be the forwarded value per REQ-024.
REQ-024 Forward priority for srcX != RNONE: e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, then register file; srcX=RNONE yields 0.
REQ-025 Register file SHALL write W_valE to W_dstE and W_valM to W_dstM on the rising clk edge; W_dstM wins when both target the same ID; writes to RNONE are ignored.
REQ-026 Register-file reads SHALL be asynchronous; a same-cycle write is visible only via forwarding (REQ-024).
REQ-027 Invalid icode (>B) SHALL pass through unchanged with all register IDs RNONE; f_stat passes through unmodified.

Reset
REQ-028 When rst_n=0 at a rising edge, the D register SHALL load the REQ-018 bubble and all registers SHALL clear to 0, overriding D_stall, D_bubble and all writes.
REQ-029 After reset: d_icode=1, d_stat=AOK, d_srcA/d_srcB/d_dstE/d_dstM=RNONE, d_valA=d_valB=d_valC=0.

Configuration
REQ-030 Macro DECODE_FWD_EN defined: forwarding per REQ-024 is compiled in.
REQ-031 Macro DECODE_FWD_EN undefined: d_valA/d_valB SHALL come only from the register file (icode 7/8 valP rule kept); hazard control covers data dependences by stalling.

Structure
REQ-032 Shared package y86_pkg SHALL hold the icode constants (HALT..POPQ), stat codes (AOK/HLT/ADR/INS), RNONE and RSP.
REQ-033 The register file SHALL be a sub-module named regfile (two async read ports, two sync write ports, sync reset).

Verification
REQ-034 Reset, then idle -> d_icode=1, d_stat=1, all IDs 4'hF, values 0.
REQ-035 Write W_dstE=3, W_valE=10; next cycle fetch 6003 (addq rax,rbx) -> d_srcA=0, d_srcB=3, d_valB=10, d_dstE=3.
REQ-036 D holds 6003 with e_dstE=3/e_valE=7 and M_dstE=3/M_valE=9 -> d_valB=7; with DECODE_FWD_EN undefined -> register-file value.
REQ-037 D_stall=1 and D_bubble=1 together for 2 cycles -> D contents unchanged; D_bubble alone -> nop.
REQ-038 W_dstE=W_dstM=2, W_valE=1, W_valM=5 -> register 2 reads 5; fetch call (icode 8) with valP=0x2A -> d_valA=0x2A, d_srcB=d_dstE=4.
